sprite_move_scheduler: RTL
==========================

// Module: sprite_move_scheduler
// PURPOSE
//  Time-multiplexes one shared position_update_function instance across the five sprites.
//  Sprite order is pacman=0, blinky=1, pinky=2, inky=3, clyde=4.
//  Each game tick it walks the sprites in order, drives the updater and stores the new position.
//  Owns the authoritative position registers and flags ghost/pacman collisions.
// PARAMETERS
//  SETTLE_CYCLES   2      cycles the updater inputs are held before new_pos is sampled (>=1)
//  NUM_SPRITES     5      sprite count, fixed; index 0 = pacman
//  RST_X0..RST_X4  1367,1399,439,1031,1415   per-sprite reset x (11b)
//  RST_Y0..RST_Y4  306,130,434,402,66        per-sprite reset y (10b)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  tick         in   1   one-cycle frame strobe; starts a sweep
//  freeze       in   1   1 = ignore ticks (pause)
//  pac_dir      in   4   pacman one-hot direction (R=0001 U=0010 D=0100 L=1000)
//  ghost_dir    in   16  ghost directions; [4*(g-1)+:4] for sprite g=1..4
//  upd_cur_x    out  11  to updater curr_pos_x
//  upd_cur_y    out  10  to updater curr_pos_y
//  upd_dir      out  4   to updater move_direction
//  upd_sprite   out  3   to updater which_sprite
//  upd_new_x    in   11  from updater new_pos_x
//  upd_new_y    in   10  from updater new_pos_y
//  pos_x        out  55  sprite i x at [11*i+:11]
//  pos_y        out  50  sprite i y at [10*i+:10]
//  busy         out  1   sweep in progress (state != IDLE)
//  frame_done   out  1   one-cycle pulse, sweep complete
//  collision    out  4   bit g-1 = ghost g on pacman's cell; held until next frame_done
//  overrun      out  1   sticky: tick arrived while busy
// BEHAVIOUR
//  Reset (sync, overrides all, any state):
//   - pos = RST_*; state = IDLE; idx = 0
//   - busy, frame_done, collision, overrun, upd_* = 0
//   - An in-flight sweep is abandoned; no partial store.
//  FSM: IDLE -> LOAD -> WAIT -> STORE -> (LOAD | DONE) -> IDLE
//   - IDLE: on tick & !freeze, snapshot pac_dir/ghost_dir into dir regs; idx = 0; go LOAD.
//     Direction input changes mid-sweep have no effect.
//   - LOAD (1 cycle): upd_cur_x/y = pos[idx]; upd_dir = dir[idx]; upd_sprite = idx;
//     cnt = SETTLE_CYCLES-1. upd_* stay stable from LOAD through STORE.
//   - WAIT: stay while cnt != 0, decrementing; cnt == 0 -> STORE. Total SETTLE_CYCLES cycles.
//   - STORE (1 cycle): pos[idx] <= {upd_new_x, upd_new_y}.
//     idx == 4 -> DONE; else idx++ -> LOAD.
//   - DONE (1 cycle): frame_done = 1; collision[g-1] <= (pos[g] == pos[0]) for g=1..4,
//     compared on post-store values; next IDLE.
//  Latency: tick sampled at cycle 0 -> frame_done at cycle 1 + 5*(SETTLE_CYCLES+2).
//   Default: cycle 21. Earliest accepted next tick is cycle 22 (IDLE).
//  Tick in any non-IDLE state: ignored, overrun <= 1. Tick with freeze=1 in IDLE:
//   ignored, overrun unchanged.
//  No arithmetic on positions here. Wrap-around and wall checks belong to the updater;
//   stored values are taken verbatim.
//  Outputs are registered; pos_x/pos_y change only in STORE or reset.
// TESTING
//  1. rst 1 cycle -> pos_x[10:0]=1367, pos_y[9:0]=306, sprite4 = (1415,66); all flags 0.
//  2. Stub updater new = cur+16 in x; one tick -> frame_done at cycle 21;
//     pacman x=1383, blinky x=1415.
//  3. Tick at cycles 0 and 10 -> single sweep, overrun=1 from cycle 11; second tick no effect.
//  4. Change pac_dir at cycle 3 -> upd_dir for sprite 0 equals snapshot; each upd_* is held
//     SETTLE_CYCLES+2 cycles.
//  5. Stub returns pacman's cell for sprite 2 -> collision=4'b0010 at frame_done, held until next frame_done.
//  6. rst asserted at cycle 9 -> next cycle IDLE, busy=0, all pos = RST_*; freeze=1 + tick -> busy stays 0.

Source files
------------

// File: rtl/sprite_move_scheduler_if.sv
// Bus between the sprite move scheduler and the shared position updater.
// The scheduler presents one sprite's state; the updater answers combinationally.
interface sprite_move_scheduler_if;
  logic [10:0] upd_cur_x;
  logic [9:0]  upd_cur_y;
  logic [3:0]  upd_dir;
  logic [2:0]  upd_sprite;
  logic [10:0] upd_new_x;
  logic [9:0]  upd_new_y;

  modport master (
    output upd_cur_x,
    output upd_cur_y,
    output upd_dir,
    output upd_sprite,
    input  upd_new_x,
    input  upd_new_y
  );

  modport slave (
    input  upd_cur_x,
    input  upd_cur_y,
    input  upd_dir,
    input  upd_sprite,
    output upd_new_x,
    output upd_new_y
  );
endinterface

// File: rtl/sprite_move_scheduler.sv
// Sweeps the five sprites through one shared position updater per tick,
// owns the position registers and flags ghost/pacman collisions.
module sprite_move_scheduler #(
  parameter int          SETTLE_CYCLES = 2,
  parameter int          NUM_SPRITES   = 5,
  parameter logic [10:0] RST_X0 = 11'd1367,
  parameter logic [10:0] RST_X1 = 11'd1399,
  parameter logic [10:0] RST_X2 = 11'd439,
  parameter logic [10:0] RST_X3 = 11'd1031,
  parameter logic [10:0] RST_X4 = 11'd1415,
  parameter logic [9:0]  RST_Y0 = 10'd306,
  parameter logic [9:0]  RST_Y1 = 10'd130,
  parameter logic [9:0]  RST_Y2 = 10'd434,
  parameter logic [9:0]  RST_Y3 = 10'd402,
  parameter logic [9:0]  RST_Y4 = 10'd66
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        freeze,
  input  logic [3:0]  pac_dir,
  input  logic [15:0] ghost_dir,
  sprite_move_scheduler_if.master upd,
  output logic [54:0] pos_x,
  output logic [49:0] pos_y,
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  collision,
  output logic        overrun
);

  localparam int CW = (SETTLE_CYCLES > 1) ?
                      $clog2(SETTLE_CYCLES) : 1;
  localparam logic [2:0] LAST = 3'(NUM_SPRITES - 1);
  localparam logic [54:0] RX = {RST_X4, RST_X3, RST_X2,
                                RST_X1, RST_X0};
  localparam logic [49:0] RY = {RST_Y4, RST_Y3, RST_Y2,
                                RST_Y1, RST_Y0};

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT, STORE, DONE
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [CW-1:0] cnt;
  logic [19:0]   dir_q;
  logic [3:0]    coll_nx;

  assign idx_nx = idx + 3'd1;

  // Last sprite is compared on the value being stored this cycle,
  // so collision lands together with frame_done.
  always_comb begin
    coll_nx = '0;
    for (int g = 1; g < 4; g++) begin
      coll_nx[g-1] = (pos_x[11*g +: 11] == pos_x[10:0]) &&
                     (pos_y[10*g +: 10] == pos_y[9:0]);
    end
    coll_nx[3] = (upd.upd_new_x == pos_x[10:0]) &&
                 (upd.upd_new_y == pos_y[9:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      dir_q          <= '0;
      pos_x          <= RX;
      pos_y          <= RY;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      collision      <= '0;
      overrun        <= 1'b0;
      upd.upd_cur_x  <= '0;
      upd.upd_cur_y  <= '0;
      upd.upd_dir    <= '0;
      upd.upd_sprite <= '0;
    end else begin
      frame_done <= 1'b0;
      if (tick && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (tick && !freeze) begin
            dir_q          <= {ghost_dir, pac_dir};
            idx            <= '0;
            upd.upd_cur_x  <= pos_x[10:0];
            upd.upd_cur_y  <= pos_y[9:0];
            upd.upd_dir    <= pac_dir;
            upd.upd_sprite <= '0;
            busy           <= 1'b1;
            state          <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= CW'(SETTLE_CYCLES - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != '0)
            cnt <= cnt - 1'b1;
          else
            state <= STORE;
        end
        STORE: begin
          pos_x[11*int'(idx) +: 11] <= upd.upd_new_x;
          pos_y[10*int'(idx) +: 10] <= upd.upd_new_y;
          if (idx == LAST) begin
            frame_done <= 1'b1;
            collision  <= coll_nx;
            state      <= DONE;
          end else begin
            idx            <= idx_nx;
            upd.upd_cur_x  <= pos_x[11*int'(idx_nx) +: 11];
            upd.upd_cur_y  <= pos_y[10*int'(idx_nx) +: 10];
            upd.upd_dir    <= dir_q[4*int'(idx_nx) +: 4];
            upd.upd_sprite <= idx_nx;
            state          <= LOAD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
